// File: rtl/alu_md_exec.sv
// EX-stage ALU: single-cycle add/sub/and/or/slt plus a WIDTH-cycle sequential
// unsigned multiply/divide into HI/LO with a busy/ready stall handshake.
module alu_md_exec #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALUOperation,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             out_valid,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_MULTU = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_SUB   = 3'b110;
   localparam logic [2:0] OP_SLT   = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
   logic [WIDTH-1:0] simple_res;
   logic [WIDTH:0]   mul_sum, div_part;
   logic [WIDTH-1:0] div_diff, step_hi, step_lo;
   logic             div_ge, accept, last, is_md;

   assign in_ready = !busy;
   assign accept   = in_valid && !busy;
   assign last     = (cnt == CW'(WIDTH - 1));
   assign is_md    = (ALUOperation == OP_MULTU) || (ALUOperation == OP_DIVU);

   always_comb begin
      simple_res = '0;
      case (ALUOperation)
         OP_ADD:  simple_res = src_a + src_b;
         OP_SUB:  simple_res = src_a - src_b;
         OP_AND:  simple_res = src_a & src_b;
         OP_OR:   simple_res = src_a | src_b;
         OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: simple_res = '0;
      endcase
   end

   // Multiply: {acc_hi,acc_lo} holds partial product over the multiplier, shifted right each step.
   // Divide: acc_hi is the remainder, acc_lo shifts dividend bits out and quotient bits in.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_part = {acc_hi, acc_lo[WIDTH-1]};
      div_ge   = (div_part >= {1'b0, opnd});
      div_diff = div_part[WIDTH-1:0] - opnd;
      if (state == DIV) begin
         step_hi = div_ge ? div_diff : div_part[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], div_ge};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         opnd      <= '0;
         result    <= '0;
         zero      <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            MUL, DIV: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + 1'b1;
               // completion takes priority over a coincident flush
               if (last) begin
                  hi        <= step_hi;
                  lo        <= step_lo;
                  result    <= step_lo;
                  zero      <= (step_lo == '0);
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end else if (flush) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               if (accept) begin
                  if (is_md) begin
                     acc_hi <= '0;
                     acc_lo <= (ALUOperation == OP_MULTU) ? src_b : src_a;
                     opnd   <= (ALUOperation == OP_MULTU) ? src_a : src_b;
                     cnt    <= '0;
                     busy   <= 1'b1;
                     state  <= (ALUOperation == OP_MULTU) ? MUL : DIV;
                  end else begin
                     result    <= simple_res;
                     zero      <= (simple_res == '0);
                     out_valid <= 1'b1;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_md_exec.sv
// Directed bench for alu_md_exec: scoreboard of expected results popped on out_valid.
module tb_alu_md_exec;
   localparam int W = 32;

   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_MULTU = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_RSVD  = 3'b101;
   localparam logic [2:0] OP_SUB   = 3'b110;
   localparam logic [2:0] OP_SLT   = 3'b111;

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   logic         clk, rst_n, in_valid, in_ready, flush, zero, out_valid, busy;
   logic [2:0]   ALUOperation;
   logic [W-1:0] src_a, src_b, result, hi, lo;

   exp_t         sb[$];
   logic [W-1:0] m_hi, m_lo;
   int           checks, errors;

   alu_md_exec #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ALUOperation(ALUOperation), .src_a(src_a), .src_b(src_b), .flush(flush),
      .result(result), .zero(zero), .out_valid(out_valid), .busy(busy),
      .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model_simple(input logic [2:0] op, input logic [W-1:0] a, b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
         default: return '0;
      endcase
   endfunction

   // drive an op and push what the DUT must eventually report for it
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b);
      exp_t e;
      logic [2*W-1:0] p;
      ALUOperation = op; src_a = a; src_b = b; in_valid = 1'b1;
      if (op == OP_MULTU) begin
         p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
         m_hi = p[2*W-1:W]; m_lo = p[W-1:0];
         e.res = m_lo;
      end else if (op == OP_DIVU) begin
         if (b == 0) begin m_hi = a; m_lo = '1; end
         else begin m_hi = a % b; m_lo = a / b; end
         e.res = m_lo;
      end else begin
         e.res = model_simple(op, a, b);
      end
      e.z = (e.res == 0); e.hi = m_hi; e.lo = m_lo;
      sb.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      chk({tag, "_ov"}, 64'(out_valid), 64'(1));
      if (sb.size() == 0) begin
         checks++; errors++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_res"}, 64'(result), 64'(e.res));
         chk({tag, "_zero"}, 64'(zero), 64'(e.z));
         chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
         chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
      end
   endtask

   // run a multi-cycle op to completion; optionally hammer in_valid while busy
   task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a, b,
                         input bit ign);
      int nb, nrdy;
      issue(op, a, b);
      nb = 0; nrdy = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ign && i < 3) begin
            ALUOperation = OP_ADD; src_a = 5; src_b = 5; in_valid = 1'b1;
         end else in_valid = 1'b0;
         if (busy) nb++;
         if (in_ready === busy) nrdy++;
         if (out_valid) break;
      end
      chk({tag, "_busy_cycles"}, 64'(nb), 64'(W));
      chk({tag, "_ready_vs_busy"}, 64'(nrdy), 64'(0));
      chk({tag, "_busy_done"}, 64'(busy), 64'(0));
      check_out(tag);
   endtask

   initial begin
      checks = 0; errors = 0; m_hi = '0; m_lo = '0;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
      ALUOperation = OP_ADD; src_a = '0; src_b = '0;
      #12;
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_zero", 64'(zero), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_ov", 64'(out_valid), 64'(0));
      chk("rst_hilo", {hi, lo}, 64'(0));
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);

      // back-to-back simple ops
      issue(OP_ADD, 5, 7);
      @(negedge clk);
      chk("add_ready", 64'(in_ready), 64'(1));
      check_out("add");
      chk("add_const", 64'(result), 64'(12));
      issue(OP_SUB, 5, 7);
      @(negedge clk); in_valid = 1'b0;
      chk("sub_ready", 64'(in_ready), 64'(1));
      check_out("sub");
      chk("sub_const", 64'(result), 64'hFFFF_FFFE);
      @(negedge clk);
      chk("ov_single", 64'(out_valid), 64'(0));

      issue(OP_SLT, 32'hFFFF_FFFF, 1);
      @(negedge clk); check_out("slt_neg");
      issue(OP_SLT, 1, 32'hFFFF_FFFF);
      @(negedge clk); check_out("slt_pos");
      issue(OP_AND, 32'hF0F0, 32'hFF00);
      @(negedge clk); check_out("and");
      chk("and_const", 64'(result), 64'hF000);
      issue(OP_OR, 32'hF0F0, 32'h0F00);
      @(negedge clk); check_out("or");
      issue(OP_SUB, 3, 3);
      @(negedge clk); check_out("sub_zero");
      chk("sub_zero_flag", 64'(zero), 64'(1));
      issue(OP_RSVD, 32'h1234, 32'h5678);
      @(negedge clk); in_valid = 1'b0; check_out("rsvd");

      // multi-cycle ops
      run_md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      chk("multu_hi_const", 64'(hi), 64'hFFFF_FFFE);
      chk("multu_lo_const", 64'(lo), 64'h1);
      @(negedge clk);
      chk("multu_ov_pulse", 64'(out_valid), 64'(0));
      run_md("divu_100_7", OP_DIVU, 100, 7, 1'b0);
      chk("divu_const", {hi, lo}, {32'd2, 32'd14});
      run_md("multu_big", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      run_md("divu_big", OP_DIVU, 32'hFEDC_BA98, 32'h0001_2345, 1'b0);
      run_md("divu_9_0", OP_DIVU, 9, 0, 1'b0);
      chk("divz_const", {hi, lo}, {32'd9, 32'hFFFF_FFFF});

      // simple op accepted in the DONE cycle
      issue(OP_MULTU, 6, 7);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (out_valid) break;
      end
      check_out("mul_6_7");
      issue(OP_ADD, 40, 2);
      @(negedge clk); in_valid = 1'b0;
      check_out("add_in_done");

      // flush mid-multiply: hi/lo keep the 6*7 values, no pulse, immediate re-accept
      ALUOperation = OP_MULTU; src_a = 3; src_b = 4; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); in_valid = 1'b0;
      end
      chk("flush_busy_before", 64'(busy), 64'(1));
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'(0));
      chk("flush_ov", 64'(out_valid), 64'(0));
      chk("flush_hilo", {hi, lo}, {32'd0, 32'd42});
      issue(OP_ADD, 100, 23);
      @(negedge clk); in_valid = 1'b0;
      check_out("add_after_flush");

      // async reset mid-divide
      ALUOperation = OP_DIVU; src_a = 100; src_b = 7; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); in_valid = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_ready", 64'(in_ready), 64'(1));
      chk("arst_result", 64'(result), 64'(0));
      chk("arst_zero", 64'(zero), 64'(1));
      chk("arst_hilo", {hi, lo}, 64'(0));
      m_hi = '0; m_lo = '0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("arst_idle_ov", 64'(out_valid), 64'(0));
      issue(OP_ADD, 1, 1);
      @(negedge clk); in_valid = 1'b0;
      check_out("add_after_rst");
      chk("add_after_rst_const", 64'(result), 64'(2));
      @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
